// File: rtl/mem_arbiter_rr_if.sv
// Bundle between the round-robin line arbiter, its cache clients and the burst memory port.
// Latency: none, wires only.
// Backpressure: clients hold req_* until resp_o; memory stalls beats by holding mem_resp_i low.
// Ports: req_read_i/req_write_i/req_addr_i/req_wdata_i (clients in), resp_o/rdata_o/busy_o (clients out),
//        mem_read_o/mem_write_o/mem_addr_o/mem_wdata_o (memory out), mem_resp_i/mem_rdata_i (memory in).
interface mem_arbiter_rr_if #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
);
  logic [NUM_PORTS-1:0]            req_read_i;
  logic [NUM_PORTS-1:0]            req_write_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata_i;
  logic [NUM_PORTS-1:0]            resp_o;
  logic [LINE_WIDTH-1:0]           rdata_o;
  logic                            busy_o;
  logic                            mem_read_o;
  logic                            mem_write_o;
  logic [ADDR_WIDTH-1:0]           mem_addr_o;
  logic [BURST_WIDTH-1:0]          mem_wdata_o;
  logic                            mem_resp_i;
  logic [BURST_WIDTH-1:0]          mem_rdata_i;

  // Arbiter side.
  modport slave (
    input  req_read_i, req_write_i, req_addr_i, req_wdata_i, mem_resp_i, mem_rdata_i,
    output resp_o, rdata_o, busy_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

  // Environment side: clients plus memory.
  modport master (
    output req_read_i, req_write_i, req_addr_i, req_wdata_i, mem_resp_i, mem_rdata_i,
    input  resp_o, rdata_o, busy_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter serialising whole-line reads/writes from NUM_PORTS clients onto one burst memory port.
// Latency: grant cycle + BEATS beat cycles (zero-wait) + one resp_o cycle; one line per BEATS+2 cycles.
// Backpressure: mem_resp_i low freezes the burst; transactions are atomic once granted, other requests wait.
// Ports: clk, reset_n (async active-low); bus (slave modport of mem_arbiter_rr_if) carries client and memory sides.
module mem_arbiter_rr #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
) (
  input logic             clk,
  input logic             reset_n,
  mem_arbiter_rr_if.slave bus
);
  localparam int BEATS  = LINE_WIDTH / BURST_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GNT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int OFF_W  = $clog2(LINE_WIDTH / 8);

  // Byte-offset bits inside a line; cleared so memory always sees a line-aligned address.
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [GNT_W-1:0]      grant_q, grant_d;
  logic [GNT_W-1:0]      last_q, last_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] buf_q, buf_d;

  logic [NUM_PORTS-1:0]  req_any;
  logic                  pick_vld;
  logic [GNT_W-1:0]      pick_idx;
  int                    cand;

  assign req_any = bus.req_read_i | bus.req_write_i;

  // Scan upward from the port after the last winner, wrapping; the first requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = (int'(last_q) + k) % NUM_PORTS;
      if (!pick_vld && req_any[GNT_W'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = GNT_W'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    grant_d = grant_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          // A port raising both read and write is serviced as a write.
          wr_d    = bus.req_write_i[pick_idx];
          addr_d  = bus.req_addr_i[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH] & ~OFF_MASK;
          // Capture the whole line now so the client may change its data after grant.
          if (bus.req_write_i[pick_idx]) begin
            buf_d = bus.req_wdata_i[int'(pick_idx)*LINE_WIDTH +: LINE_WIDTH];
          end
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (bus.mem_resp_i) begin
          if (!wr_q) begin
            buf_d[int'(beat_q)*BURST_WIDTH +: BURST_WIDTH] = bus.mem_rdata_i;
          end
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_RESP;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_RESP: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      grant_q <= '0;
      // Pointing at the highest port makes port 0 the first winner after reset.
      last_q  <= GNT_W'(NUM_PORTS - 1);
      wr_q    <= 1'b0;
      addr_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  // Every output is a pure function of reset-cleared flops, so all drop as soon as reset asserts.
  always_comb begin
    bus.resp_o = '0;
    if (state_q == ST_RESP) begin
      bus.resp_o[grant_q] = 1'b1;
    end
  end

  assign bus.rdata_o     = buf_q;
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.mem_read_o  = (state_q == ST_XFER) && !wr_q;
  assign bus.mem_write_o = (state_q == ST_XFER) && wr_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = buf_q[int'(beat_q)*BURST_WIDTH +: BURST_WIDTH];
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: two-port instance against a transaction model, plus a three-port instance for rotation order.
// Latency: n/a.
// Backpressure: bench memory inserts a programmable number of idle cycles before each beat.
module tb_mem_arbiter_rr;
  localparam int NP    = 2;
  localparam int AW    = 32;
  localparam int LW    = 256;
  localparam int BW    = 64;
  localparam int BEATS = LW / BW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_rr_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BURST_WIDTH(BW)) bus2 ();
  mem_arbiter_rr_if #(.NUM_PORTS(3),  .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BURST_WIDTH(BW)) bus3 ();

  mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BURST_WIDTH(BW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave));
  mem_arbiter_rr #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BURST_WIDTH(BW)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  function automatic logic [BW-1:0] beat_pat(input int b);
    logic [BW-1:0] one;
    one = 64'h1111_1111_1111_1111;
    return one * BW'(b + 1);
  endfunction

  function automatic int onehot_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Three-port instance: ports 0 and 2 request forever against a zero-wait memory.
  assign bus3.req_read_i  = 3'b101;
  assign bus3.req_write_i = 3'b000;
  assign bus3.req_addr_i  = '0;
  assign bus3.req_wdata_i = '0;
  assign bus3.mem_resp_i  = bus3.mem_read_o | bus3.mem_write_o;
  assign bus3.mem_rdata_i = '0;

  int log3[$];
  int log2[$];
  always @(negedge clk) begin
    if (bus3.resp_o != 3'b000 && log3.size() < 8) log3.push_back(onehot_idx(8'(bus3.resp_o)));
    if (bus2.resp_o != 2'b00) log2.push_back(onehot_idx(8'(bus2.resp_o)));
  end

  // Bench memory: mem_wait idle cycles before each beat, read data = beat pattern ^ seed, writes logged.
  int            mem_wait = 0;
  logic [31:0]   rd_seed  = 32'h0;
  int            wcnt = 0;
  int            rbeat = 0;
  logic [BW-1:0] wlog[$];
  always @(posedge clk) begin
    #1;
    if (!reset_n || !(bus2.mem_read_o || bus2.mem_write_o)) begin
      bus2.mem_resp_i = 1'b0;
      wcnt = 0;
      rbeat = 0;
    end else if (wcnt >= mem_wait) begin
      bus2.mem_resp_i  = 1'b1;
      bus2.mem_rdata_i = beat_pat(rbeat) ^ {2{rd_seed}};
      if (bus2.mem_write_o) wlog.push_back(bus2.mem_wdata_o);
      rbeat++;
      wcnt = 0;
    end else begin
      bus2.mem_resp_i = 1'b0;
      wcnt++;
    end
  end

  // Transaction-level reference: which port owns the memory, how many beats it has moved, the line it carries.
  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] addr;
    logic [LW-1:0] line;
  } txn_t;

  txn_t cur;
  bit   m_busy;
  int   m_beats;
  int   m_last;

  function automatic int rr_pick(input logic [NP-1:0] r, input int last);
    for (int k = 1; k <= NP; k++) begin
      int c = (last + k) % NP;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic txn_t make_txn(input int p, input logic [LW-1:0] keep);
    txn_t t;
    t.port = p;
    t.wr   = bus2.req_write_i[p];
    t.addr = bus2.req_addr_i[p*AW +: AW] & ~32'h1F;
    t.line = t.wr ? bus2.req_wdata_i[p*LW +: LW] : keep;
    return t;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  <= 1'b0;
      m_beats <= 0;
      m_last  <= NP - 1;
    end else if (!m_busy) begin
      if (rr_pick(bus2.req_read_i | bus2.req_write_i, m_last) >= 0) begin
        cur     <= make_txn(rr_pick(bus2.req_read_i | bus2.req_write_i, m_last), cur.line);
        m_busy  <= 1'b1;
        m_beats <= 0;
      end
    end else if (m_beats < BEATS) begin
      if (bus2.mem_resp_i) begin
        if (!cur.wr) cur.line[m_beats*BW +: BW] <= bus2.mem_rdata_i;
        m_beats <= m_beats + 1;
      end
    end else begin
      m_last  <= cur.port;
      m_busy  <= 1'b0;
      m_beats <= 0;
    end
  end

  logic          m_xfer;
  logic          m_done;
  logic [NP-1:0] exp_resp;
  assign m_xfer   = m_busy && (m_beats < BEATS);
  assign m_done   = m_busy && (m_beats == BEATS);
  assign exp_resp = m_done ? (NP'(1) << cur.port) : '0;

  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy_o", LW'(bus2.busy_o), LW'(m_busy));
      chk("resp_o", LW'(bus2.resp_o), LW'(exp_resp));
      chk("mem_read_o", LW'(bus2.mem_read_o), LW'(m_xfer && !cur.wr));
      chk("mem_write_o", LW'(bus2.mem_write_o), LW'(m_xfer && cur.wr));
      if (m_xfer) chk("mem_addr_o", LW'(bus2.mem_addr_o), LW'(cur.addr));
      if (m_xfer && cur.wr) chk("mem_wdata_o", LW'(bus2.mem_wdata_o), LW'(cur.line[m_beats*BW +: BW]));
      if (m_done && !cur.wr) chk("rdata_o", bus2.rdata_o, cur.line);
    end
  end

  // One client transaction on port p; client scribbles over its write data right after grant.
  task automatic do_txn(input int p, input bit wr, input logic [31:0] addr, input logic [LW-1:0] wd,
                        output int lat, output logic [NP-1:0] rv, output logic [31:0] addr_seen);
    bit done;
    done = 1'b0;
    lat = 0;
    rv = '0;
    addr_seen = '0;
    @(posedge clk); #1;
    bus2.req_read_i[p]  = !wr;
    bus2.req_write_i[p] = wr;
    bus2.req_addr_i[p*AW +: AW] = addr;
    bus2.req_wdata_i[p*LW +: LW] = wd;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      if (lat == 1 && wr) begin #1; bus2.req_wdata_i[p*LW +: LW] = ~wd; end
      @(negedge clk);
      if (lat == 1) addr_seen = bus2.mem_addr_o;
      if (bus2.resp_o != '0) begin rv = bus2.resp_o; done = 1'b1; end
    end
    if (!done) tmo("txn_resp");
    @(posedge clk); #1;
    bus2.req_read_i[p]  = 1'b0;
    bus2.req_write_i[p] = 1'b0;
    bus2.req_wdata_i[p*LW +: LW] = '0;
  endtask

  task automatic wait_log2(input int n, input string nm);
    int c;
    c = 0;
    while (log2.size() < n && c < 300) begin @(negedge clk); #1; c++; end
    if (log2.size() < n) tmo(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            lat;
    logic [NP-1:0] rv;
    logic [31:0]   aseen;
    logic [LW-1:0] line;
    int            exp3[4];
    int            c;
    exp3 = '{0, 2, 0, 2};

    bus2.req_read_i  = '0;
    bus2.req_write_i = '0;
    bus2.req_addr_i  = '0;
    bus2.req_wdata_i = '0;

    // Reset state, sampled between edges.
    #12;
    chk("rst_busy", LW'(bus2.busy_o), LW'(1'b0));
    chk("rst_resp", LW'(bus2.resp_o), LW'(2'b00));
    chk("rst_strobes", LW'({bus2.mem_read_o, bus2.mem_write_o}), LW'(2'b00));
    chk("rst_rdata", bus2.rdata_o, '0);
    chk("rst_addr", LW'(bus2.mem_addr_o), LW'(32'h0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Port 0 read, zero-wait memory.
    do_txn(0, 1'b0, 32'h0000_1234, '0, lat, rv, aseen);
    chk("rd_latency", LW'(lat), LW'(5));
    chk("rd_addr", LW'(aseen), LW'(32'h0000_1220));
    chk("rd_resp", LW'(rv), LW'(2'b01));
    chk("rd_line", bus2.rdata_o,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // Port 1 write; its data is scrambled after grant but the captured line must go out.
    wlog.delete();
    do_txn(1, 1'b1, 32'h0000_0080,
           256'hCAFEF00D00000003_DEADBEEF00000002_FEDCBA9876543210_0123456789ABCDEF, lat, rv, aseen);
    chk("wr_resp", LW'(rv), LW'(2'b10));
    chk("wr_addr", LW'(aseen), LW'(32'h0000_0080));
    chk("wr_nbeats", LW'(wlog.size()), LW'(4));
    chk("wr_beat0", LW'(wlog[0]), LW'(64'h0123456789ABCDEF));
    chk("wr_beat1", LW'(wlog[1]), LW'(64'hFEDCBA9876543210));
    chk("wr_beat2", LW'(wlog[2]), LW'(64'hDEADBEEF00000002));
    chk("wr_beat3", LW'(wlog[3]), LW'(64'hCAFEF00D00000003));

    // Both ports read continuously: last winner was 1, so 0,1,0,1.
    log2.delete();
    @(posedge clk); #1;
    bus2.req_addr_i = {32'h0000_0200, 32'h0000_0100};
    bus2.req_read_i = 2'b11;
    wait_log2(4, "alt_grants");
    @(posedge clk); #1;
    bus2.req_read_i = 2'b00;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("alt_grant%0d", i), LW'(log2[i]), LW'(i % 2));

    // Three-port rotation with ports 0 and 2 requesting; port 1 never served.
    chk("p3_count", LW'(log3.size() >= 4), LW'(1'b1));
    for (int i = 0; i < 4; i++) chk($sformatf("p3_grant%0d", i), LW'(log3[i]), LW'(exp3[i]));

    // Read with three idle memory cycles before every beat.
    mem_wait = 3;
    rd_seed  = 32'hA5A5_0F0F;
    do_txn(1, 1'b0, 32'h4000_0037, '0, lat, rv, aseen);
    line = {beat_pat(3), beat_pat(2), beat_pat(1), beat_pat(0)} ^ {8{rd_seed}};
    chk("slow_latency", LW'(lat), LW'(17));
    chk("slow_addr", LW'(aseen), LW'(32'h4000_0020));
    chk("slow_resp", LW'(rv), LW'(2'b10));
    chk("slow_line", bus2.rdata_o, line);
    mem_wait = 0;
    rd_seed  = 32'h0;

    // Reset during the third beat of a port 1 write; port 0 must win first afterwards.
    wlog.delete();
    @(posedge clk); #1;
    bus2.req_addr_i[AW +: AW] = 32'h0000_0300;
    bus2.req_wdata_i[LW +: LW] = {4{64'h5A5A_5A5A_0000_FFFF}};
    bus2.req_write_i[1] = 1'b1;
    c = 0;
    while (wlog.size() < 3 && c < 100) begin @(negedge clk); #1; c++; end
    if (wlog.size() < 3) tmo("mid_burst");
    chk("pre_rst_write", LW'(bus2.mem_write_o), LW'(1'b1));
    reset_n = 1'b0;
    #1;
    chk("rst_drop_write", LW'(bus2.mem_write_o), LW'(1'b0));
    chk("rst_drop_busy", LW'(bus2.busy_o), LW'(1'b0));
    chk("rst_drop_resp", LW'(bus2.resp_o), LW'(2'b00));
    bus2.req_addr_i[0 +: AW] = 32'h0000_0500;
    bus2.req_read_i[0] = 1'b1;
    log2.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_log2(1, "post_rst_first");
    chk("post_rst_first", LW'(log2[0]), LW'(0));
    @(posedge clk); #1;
    bus2.req_read_i[0] = 1'b0;
    wait_log2(2, "post_rst_second");
    chk("post_rst_second", LW'(log2[1]), LW'(1));
    @(posedge clk); #1;
    bus2.req_write_i[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("end_idle", LW'(bus2.busy_o), LW'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
